// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// frame geometry. Kept in a package so a future UART receive checker can
// reuse the same encodings.
package uart_tx_fifo_pkg;

  // Number of data bits per frame and total bits per frame (start + data + stop)
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  // Transmit FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO used as the transmit queue. The head entry is always
// visible on dout_o. Occupancy comes from its own counter so that full and
// empty are unambiguous when the pointers wrap. A push is accepted only when
// the registered full flag is low, even if a pop happens in the same cycle.
module uart_tx_fifo_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic          full_q;
  logic          empty_q;
  logic          overflow_q;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign push_ok_s = push_i && !full_q;
  assign pop_ok_s  = pop_i && !empty_q;

  // Next occupancy: push and pop together leave the level unchanged
  always_comb begin
    level_d = level_q;
    if (push_ok_s && !pop_ok_s) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      level_d = level_q - (AW+1)'(1);
    end else begin
      level_d = level_q;
    end
  end

  // Storage array; contents need no reset because the level gates every read
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  // Pointers, occupancy, flags and the overflow pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rptr_q <= rptr_q + AW'(1);
      end
      level_q    <= level_d;
      full_q     <= (level_d == (AW+1)'(DEPTH));
      empty_q    <= (level_d == '0);
      overflow_q <= push_i && full_q;
    end
  end

  assign dout_o     = mem_q[rptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a write-side FIFO. Queued bytes are sent LSB
// first, CLKS_PER_BIT clocks per bit, with no idle gap between frames while
// data is queued and tx_en is high. Dropping tx_en lets the current frame
// finish and then holds the line idle with the queue intact.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [7:0]         wdata,
  input  logic               wr,
  input  logic               tx_en,
  output logic               tx,
  output logic               busy,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic               overflow
);

  localparam int            PW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BCNT_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_e     state_q;
  logic [PW-1:0] pcnt_q;
  logic [2:0]    bcnt_q;
  logic [7:0]    shreg_q;
  logic          tx_q;
  logic          busy_q;

  logic [7:0]    head_s;
  logic          fifo_empty_s;
  logic          bit_end_s;
  logic          can_start_s;
  logic          pop_s;

  uart_tx_fifo_sync_fifo #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .push_i     (wr),
    .din_i      (wdata),
    .pop_i      (pop_s),
    .dout_o     (head_s),
    .full_o     (full),
    .empty_o    (fifo_empty_s),
    .level_o    (level),
    .overflow_o (overflow)
  );

  assign bit_end_s   = (pcnt_q == PCNT_LAST);
  assign can_start_s = tx_en && !fifo_empty_s;

  // Pop the head whenever a new frame is launched (from idle or at stop end)
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      ST_IDLE: pop_s = can_start_s;
      ST_STOP: pop_s = can_start_s && bit_end_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Frame sequencer: prescaler, bit counter, shift register and registered line
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      bcnt_q  <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pcnt_q <= '0;
          if (can_start_s) begin
            shreg_q <= head_s;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end else begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            pcnt_q  <= '0;
            bcnt_q  <= 3'd0;
            tx_q    <= shreg_q[0];
            state_q <= ST_DATA;
          end else begin
            pcnt_q  <= pcnt_q + PW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            pcnt_q <= '0;
            if (bcnt_q == BCNT_LAST) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bcnt_q  <= bcnt_q + 3'd1;
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
            end
          end else begin
            pcnt_q <= pcnt_q + PW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            pcnt_q <= '0;
            if (can_start_s) begin
              // Next frame starts with no idle cycle after the stop bit
              shreg_q <= head_s;
              tx_q    <= 1'b0;
              state_q <= ST_START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            pcnt_q <= pcnt_q + PW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pcnt_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign empty = fifo_empty_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. A frame-level model (byte queue plus
// position within the current 10-bit frame) predicts every output each cycle;
// a simple serial receiver decodes the line and the decoded byte stream is
// checked against the literal list of bytes that must appear.
module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [7:0] wdata;
  logic       wr;
  logic       tx_en;
  logic       tx;
  logic       busy;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int rst_cnt = 0;

  // model state
  logic [7:0] mq[$];
  bit         m_act = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 1'b0;

  // receiver state
  logic [7:0] rxq[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_byte;
  logic       rx_stop;
  int         rx_r0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .wdata    (wdata),
    .wr       (wr),
    .tx_en    (tx_en),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  initial forever #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line level the model expects: start bit, 8 data bits LSB first, stop bit
  function automatic logic exp_tx();
    int k;
    if (!m_act) return 1'b1;
    k = m_cnt / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  // Behavioural model, advanced on every clock edge
  initial forever begin
    int sz;
    bit start;
    logic [7:0] b;
    @(posedge HCLK or posedge HRESET);
    if (HRESET) begin
      mq.delete();
      m_act = 1'b0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      sz    = mq.size();
      start = (!m_act || m_cnt == FRAME - 1) && tx_en && (sz > 0);
      m_ovf = wr && (sz == DEPTH);
      b     = 8'h00;
      if (start) b = mq.pop_front();
      if (wr && sz < DEPTH) mq.push_back(wdata);
      if (start) begin
        m_act  = 1'b1;
        m_cnt  = 0;
        m_byte = b;
      end else if (m_act) begin
        if (m_cnt == FRAME - 1) m_act = 1'b0;
        else m_cnt++;
      end
    end
  end

  // Cycle-by-cycle compare of all outputs against the model
  initial forever begin
    int sz;
    @(negedge HCLK);
    if (chk_en) begin
      sz = mq.size();
      chk("cycle", {22'd0, tx, busy, full, empty, overflow, level},
          {22'd0, exp_tx(), m_act, (sz == DEPTH), (sz == 0), m_ovf, 5'(sz)});
    end
  end

  initial forever begin
    @(posedge HRESET);
    rst_cnt++;
  end

  // Serial receiver sampling mid-bit; frames cut by a reset are discarded
  initial forever begin
    @(negedge HCLK);
    if (chk_en && !HRESET && tx === 1'b0) begin
      rx_r0 = rst_cnt;
      repeat (CPB / 2) @(negedge HCLK);
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(negedge HCLK);
        rx_byte[b] = tx;
      end
      repeat (CPB) @(negedge HCLK);
      rx_stop = tx;
      if (rst_cnt == rx_r0) begin
        chk("rx_stop_bit", {31'd0, rx_stop}, 32'd1);
        rxq.push_back(rx_byte);
      end
    end
  end

  task automatic push(input logic [7:0] d);
    wr    = 1'b1;
    wdata = d;
    @(negedge HCLK);
    wr    = 1'b0;
  endtask

  // Wait until the line is quiet (and optionally the queue drained), bounded
  task automatic wait_quiet(input bit need_empty, input int bound, input string name);
    int n;
    n = 0;
    while ((busy || (need_empty && !empty)) && n < bound) begin
      @(negedge HCLK);
      n++;
    end
    chk(name, {31'd0, (!busy && (!need_empty || empty))}, 32'd1);
  endtask

  initial begin
    logic [9:0] bits41;
    int run;
    bits41 = 10'b1010000010;   // index 0 = start bit, index 9 = stop bit, byte 8'h41
    wr = 1'b0; wdata = 8'h00; tx_en = 1'b0;
    HRESET = 1'b1;

    // 1: reset state
    repeat (3) @(negedge HCLK);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    HRESET = 1'b0;
    chk_en = 1'b1;

    // 1b: reset in the middle of a frame
    tx_en = 1'b1;
    push(8'h5A);
    repeat (40) @(negedge HCLK);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 HRESET = 1'b1;
    #1;
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    chk("rst_mid_level", {27'd0, level}, 32'd0);
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (200) @(negedge HCLK);

    // 2: single byte 'A', bit-by-bit line check
    wr = 1'b1; wdata = 8'h41;
    @(negedge HCLK);
    wr = 1'b0;
    chk("t2_tx_after_e0", {31'd0, tx}, 32'd1);
    chk("t2_level_after_e0", {27'd0, level}, 32'd1);
    @(negedge HCLK);
    chk("t2_tx_after_e1", {31'd0, tx}, 32'd0);
    repeat (CPB / 2) @(negedge HCLK);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t2_bit%0d", k), {31'd0, tx}, {31'd0, bits41[k]});
      if (k < 9) repeat (CPB) @(negedge HCLK);
    end
    repeat (7) @(negedge HCLK);
    chk("t2_busy_last", {31'd0, busy}, 32'd1);
    @(negedge HCLK);
    chk("t2_busy_end", {31'd0, busy}, 32'd0);
    exp_rx.push_back(8'h41);
    repeat (20) @(negedge HCLK);

    // 3: burst "N5\n", three frames contiguous
    push(8'h4E); push(8'h35); push(8'h0A);
    run = 0;
    while (busy && run < 2000) begin
      @(negedge HCLK);
      run++;
    end
    // counting starts one cycle into the first frame: 3*160 - 1 busy cycles remain
    chk("t3_contig_busy", run, 32'd479);
    chk("t3_level", {27'd0, level}, 32'd0);
    exp_rx.push_back(8'h4E); exp_rx.push_back(8'h35); exp_rx.push_back(8'h0A);
    repeat (20) @(negedge HCLK);

    // 4: fill to full with tx held off, overflow on the 17th push
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    chk("t4_level16", {27'd0, level}, 32'd16);
    chk("t4_full", {31'd0, full}, 32'd1);
    chk("t4_no_ovf", {31'd0, overflow}, 32'd0);
    push(8'hEE);
    chk("t4_ovf_pulse", {31'd0, overflow}, 32'd1);
    chk("t4_level_kept", {27'd0, level}, 32'd16);
    @(negedge HCLK);
    chk("t4_ovf_clear", {31'd0, overflow}, 32'd0);
    tx_en = 1'b1;
    wait_quiet(1'b1, 20 * FRAME, "t4_drain_timeout");
    for (int i = 0; i < 16; i++) exp_rx.push_back(8'h10 + 8'(i));
    repeat (20) @(negedge HCLK);

    // 5: drop tx_en during byte 2 of 4
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    repeat (200) @(negedge HCLK);
    tx_en = 1'b0;
    wait_quiet(1'b0, 2 * FRAME, "t5_stop_timeout");
    chk("t5_level2", {27'd0, level}, 32'd2);
    repeat (50) @(negedge HCLK);
    chk("t5_tx_idle", {31'd0, tx}, 32'd1);
    chk("t5_level_held", {27'd0, level}, 32'd2);
    tx_en = 1'b1;
    wait_quiet(1'b1, 4 * FRAME, "t5_drain_timeout");
    exp_rx.push_back(8'hA1); exp_rx.push_back(8'hA2);
    exp_rx.push_back(8'hA3); exp_rx.push_back(8'hA4);
    repeat (20) @(negedge HCLK);

    // 6: push+pop at level 5, then push on full during a pop
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
    chk("t6_level5_pre", {27'd0, level}, 32'd5);
    tx_en = 1'b1;
    push(8'hB5);
    chk("t6_pushpop_level", {27'd0, level}, 32'd5);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 11; i++) push(8'hC0 + 8'(i));
    chk("t6_full", {31'd0, full}, 32'd1);
    repeat (148) @(negedge HCLK);
    push(8'hEE);
    chk("t6_full_pop_ovf", {31'd0, overflow}, 32'd1);
    chk("t6_full_pop_level", {27'd0, level}, 32'd15);
    wait_quiet(1'b1, 20 * FRAME, "t6_drain_timeout");
    for (int i = 0; i < 6; i++) exp_rx.push_back(8'hB0 + 8'(i));
    for (int i = 0; i < 11; i++) exp_rx.push_back(8'hC0 + 8'(i));
    repeat (50) @(negedge HCLK);

    // received byte stream, in order
    chk("rx_count", rxq.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size(); i++) begin
      if (i < rxq.size()) chk($sformatf("rx_byte%0d", i), {24'd0, rxq[i]}, {24'd0, exp_rx[i]});
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
